// File: rtl/lm_enc_pkg.sv
// Shared types for the greedy longest-match token encoder: FSM states,
// length-width helper and the vocabulary entry payload.
package lm_enc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SCAN,
    EMIT,
    DONE
  } enc_state_t;

  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_ADDR_WIDTH  = 4;
  localparam int unsigned DEF_MAX_TOK_LEN = 4;

  // Bits needed to hold a symbol count in 0..max_tok_len.
  function automatic int unsigned len_w(input int unsigned max_tok_len);
    return $clog2(max_tok_len + 1);
  endfunction

  localparam int unsigned DEF_LEN_W = len_w(DEF_MAX_TOK_LEN);

  typedef struct packed {
    logic [DEF_LEN_W-1:0]                      len;
    logic [DEF_MAX_TOK_LEN*DEF_DATA_WIDTH-1:0] syms;
  } vocab_entry_t;

endpackage

// File: rtl/lm_enc_window.sv
// Lookahead window: shift register of MAX_TOK_LEN symbols, symbol 0 in LSBs.
// Supports append at the tail, shift-down by n, and flush.
module lm_enc_window
  import lm_enc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned MAX_TOK_LEN = DEF_MAX_TOK_LEN,
  parameter int unsigned LEN_W       = len_w(MAX_TOK_LEN)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              append,
  input  logic [DATA_WIDTH-1:0]             append_sym,
  input  logic                              shift,
  input  logic [LEN_W-1:0]                  shift_n,
  output logic [MAX_TOK_LEN*DATA_WIDTH-1:0] window,
  output logic [LEN_W-1:0]                  count
);

  localparam int unsigned WIN_W = MAX_TOK_LEN * DATA_WIDTH;

  // Slots at and above count are always zero, so append can OR into place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window <= '0;
      count  <= '0;
    end else if (flush) begin
      window <= '0;
      count  <= '0;
    end else if (append && (count < LEN_W'(MAX_TOK_LEN))) begin
      window <= window | (WIN_W'(append_sym) << (DATA_WIDTH * 32'(count)));
      count  <= count + LEN_W'(1);
    end else if (shift) begin
      window <= window >> (DATA_WIDTH * 32'(shift_n));
      count  <= (shift_n >= count) ? '0 : count - shift_n;
    end
  end

endmodule

// File: rtl/lm_token_encoder.sv
// Streaming greedy longest-match tokenizer over a register-file vocabulary.
// Optional feature macro: BYTE_FALLBACK_EN (raw symbol carried on unmatched tokens).
module lm_token_encoder
  import lm_enc_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned           ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned           MAX_TOK_LEN = DEF_MAX_TOK_LEN,
  parameter logic [ADDR_WIDTH-1:0] UNK_ID      = '1,
  localparam int unsigned          LEN_W       = len_w(MAX_TOK_LEN)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cs,
  input  logic                              vocab_we,
  input  logic [ADDR_WIDTH-1:0]             vocab_waddr,
  input  logic [LEN_W-1:0]                  vocab_wlen,
  input  logic [MAX_TOK_LEN*DATA_WIDTH-1:0] vocab_wdata,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_sym,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ADDR_WIDTH-1:0]             out_token,
  output logic [LEN_W-1:0]                  out_len,
  output logic                              out_unk,
  output logic [DATA_WIDTH-1:0]             out_sym,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done,
  output logic [15:0]                       unk_cnt
);

  localparam int unsigned VOCAB_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned WIN_W       = MAX_TOK_LEN * DATA_WIDTH;

  enc_state_t            state_q;
  vocab_entry_t          vocab_q [VOCAB_DEPTH];
  logic [ADDR_WIDTH-1:0] scan_idx_q;
  logic [ADDR_WIDTH-1:0] best_idx_q;
  logic [LEN_W-1:0]      best_len_q;
  logic                  last_seen_q;

  logic [WIN_W-1:0]      window;
  logic [LEN_W-1:0]      count;

  logic                  append_c;
  logic                  shift_c;
  logic                  flush_c;
  vocab_entry_t          ent_c;
  logic                  hit_c;
  logic                  longer_c;
  logic [LEN_W-1:0]      fin_len_c;
  logic [ADDR_WIDTH-1:0] fin_idx_c;
  logic [LEN_W-1:0]      emit_len_c;

  // Handshake and status decode straight from registered state.
  assign in_ready = (state_q == FILL) && (count < LEN_W'(MAX_TOK_LEN)) && !last_seen_q;
  assign busy     = (state_q == FILL) || (state_q == SCAN) || (state_q == EMIT);
  assign done     = (state_q == DONE);

  assign append_c = in_valid && in_ready;
  assign shift_c  = (state_q == EMIT) && out_valid && out_ready;
  assign flush_c  = !cs;

  lm_enc_window #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MAX_TOK_LEN (MAX_TOK_LEN),
    .LEN_W       (LEN_W)
  ) u_window (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush_c),
    .append     (append_c),
    .append_sym (in_sym),
    .shift      (shift_c),
    .shift_n    (out_len),
    .window     (window),
    .count      (count)
  );

  // Compare the entry under scan against the window prefix; fold into best so far.
  always_comb begin
    ent_c = vocab_q[scan_idx_q];
    hit_c = (ent_c.len != '0) && (ent_c.len <= count);
    for (int k = 0; k < int'(MAX_TOK_LEN); k++) begin
      if ((LEN_W'(k) < ent_c.len) &&
          (window[k*DATA_WIDTH +: DATA_WIDTH] != ent_c.syms[k*DATA_WIDTH +: DATA_WIDTH])) begin
        hit_c = 1'b0;
      end
    end
    longer_c   = hit_c && (ent_c.len > best_len_q);
    fin_len_c  = longer_c ? ent_c.len : best_len_q;
    fin_idx_c  = longer_c ? scan_idx_q : best_idx_q;
    emit_len_c = (fin_len_c == '0) ? LEN_W'(1) : fin_len_c;
  end

  // Vocabulary is writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(VOCAB_DEPTH); i++) begin
        vocab_q[i] <= '0;
      end
    end else if ((state_q == IDLE) && vocab_we) begin
      vocab_q[vocab_waddr] <= '{len: vocab_wlen, syms: vocab_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      scan_idx_q  <= '0;
      best_idx_q  <= '0;
      best_len_q  <= '0;
      last_seen_q <= 1'b0;
      out_valid   <= 1'b0;
      out_token   <= '0;
      out_len     <= '0;
      out_unk     <= 1'b0;
      out_last    <= 1'b0;
      unk_cnt     <= '0;
`ifdef BYTE_FALLBACK_EN
      out_sym     <= '0;
`endif
    end else if (!cs) begin
      state_q     <= IDLE;
      out_valid   <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q     <= FILL;
          last_seen_q <= 1'b0;
          unk_cnt     <= '0;
        end
        FILL: begin
          if (append_c && in_last) begin
            last_seen_q <= 1'b1;
          end
          if ((count == LEN_W'(MAX_TOK_LEN)) || last_seen_q ||
              (append_c && (in_last || (count == LEN_W'(MAX_TOK_LEN - 1))))) begin
            state_q    <= SCAN;
            scan_idx_q <= '0;
            best_idx_q <= '0;
            best_len_q <= '0;
          end
        end
        SCAN: begin
          scan_idx_q <= scan_idx_q + ADDR_WIDTH'(1);
          best_len_q <= fin_len_c;
          best_idx_q <= fin_idx_c;
          if (scan_idx_q == ADDR_WIDTH'(VOCAB_DEPTH - 1)) begin
            state_q   <= EMIT;
            out_valid <= 1'b1;
            out_len   <= emit_len_c;
            out_last  <= last_seen_q && (count == emit_len_c);
            if (fin_len_c == '0) begin
              out_token <= UNK_ID;
              out_unk   <= 1'b1;
              if (unk_cnt != 16'hFFFF) begin
                unk_cnt <= unk_cnt + 16'd1;
              end
`ifdef BYTE_FALLBACK_EN
              out_sym   <= window[DATA_WIDTH-1:0];
`endif
            end else begin
              out_token <= fin_idx_c;
              out_unk   <= 1'b0;
`ifdef BYTE_FALLBACK_EN
              out_sym   <= '0;
`endif
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!last_seen_q) begin
              state_q <= FILL;
            end else if (count != out_len) begin
              state_q    <= SCAN;
              scan_idx_q <= '0;
              best_idx_q <= '0;
              best_len_q <= '0;
            end else begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifndef BYTE_FALLBACK_EN
  assign out_sym = '0;
`endif

endmodule

// File: tb/tb_lm_token_encoder.sv
// Scoreboard bench for lm_token_encoder: directed vocabulary cases plus random
// streams checked against a greedy longest-match reference model.
module tb_lm_token_encoder;

  localparam int MAXL = 4;
  localparam logic [7:0] SA = 8'h61;
  localparam logic [7:0] SB = 8'h62;
  localparam logic [7:0] SC = 8'h63;
  localparam logic [7:0] SX = 8'h78;
`ifdef BYTE_FALLBACK_EN
  localparam bit FALLBACK = 1'b1;
`else
  localparam bit FALLBACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, cs, vocab_we;
  logic [3:0]  vocab_waddr;
  logic [2:0]  vocab_wlen;
  logic [31:0] vocab_wdata;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_sym;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_token;
  logic [2:0]  out_len;
  logic        out_unk, out_last, busy, done;
  logic [7:0]  out_sym;
  logic [15:0] unk_cnt;

  typedef struct {
    logic [3:0] tok;
    logic [2:0] len;
    logic       unk;
    logic       last;
    logic [7:0] sym;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         rdy_mode = 0;
  int         m_len[16];
  logic [7:0] m_sym[16][4];

  lm_token_encoder #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .MAX_TOK_LEN(4), .UNK_ID(4'd15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs),
    .vocab_we(vocab_we), .vocab_waddr(vocab_waddr), .vocab_wlen(vocab_wlen),
    .vocab_wdata(vocab_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_token(out_token),
    .out_len(out_len), .out_unk(out_unk), .out_sym(out_sym), .out_last(out_last),
    .busy(busy), .done(done), .unk_cnt(unk_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sink readiness policy: 0 always ready, 1 random, 2 stalled.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else                    out_ready = 1'b0;
  end

  // Monitor: every accepted token is checked against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_token got=%0d expected=none", out_token);
      end else begin
        e = exp_q.pop_front();
        chk("out_token", 32'(out_token), 32'(e.tok));
        chk("out_len",   32'(out_len),   32'(e.len));
        chk("out_unk",   32'(out_unk),   32'(e.unk));
        chk("out_last",  32'(out_last),  32'(e.last));
        chk("out_sym",   32'(out_sym),   32'(e.sym));
      end
    end
  end

  task automatic push_exp(input int tok, input int len, input bit unk, input bit last,
                          input logic [7:0] sym);
    exp_t e;
    e.tok = 4'(tok); e.len = 3'(len); e.unk = unk; e.last = last; e.sym = sym;
    exp_q.push_back(e);
  endtask

  // Reference: greedy longest match over the remaining stream, lowest index on ties.
  task automatic model_push(input logic [7:0] s[$], output int unk);
    int pos, n, best_len, best_idx, avail, l;
    bit ok;
    pos = 0; n = s.size(); unk = 0;
    while (pos < n) begin
      best_len = 0; best_idx = 0;
      avail = (n - pos < MAXL) ? n - pos : MAXL;
      for (int v = 0; v < 16; v++) begin
        l = m_len[v];
        if (l > best_len && l <= avail) begin
          ok = 1'b1;
          for (int k = 0; k < l; k++) if (s[pos+k] !== m_sym[v][k]) ok = 1'b0;
          if (ok) begin best_len = l; best_idx = v; end
        end
      end
      if (best_len == 0) begin
        push_exp(15, 1, 1'b1, (pos + 1 == n), FALLBACK ? s[pos] : 8'h00);
        unk++;
        pos += 1;
      end else begin
        push_exp(best_idx, best_len, 1'b0, (pos + best_len == n), 8'h00);
        pos += best_len;
      end
    end
  endtask

  task automatic write_vocab(input int idx, input int len, input logic [7:0] s0,
                             input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
    vocab_we = 1'b1; vocab_waddr = 4'(idx); vocab_wlen = 3'(len);
    vocab_wdata = {s3, s2, s1, s0};
    tick();
    vocab_we = 1'b0;
    m_len[idx] = len;
    m_sym[idx][0] = s0; m_sym[idx][1] = s1; m_sym[idx][2] = s2; m_sym[idx][3] = s3;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gaps);
    int g;
    bit acc;
    for (int i = 0; i < s.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin in_valid = 1'b0; tick(); end
      in_valid = 1'b1; in_sym = s[i]; in_last = (i == s.size() - 1);
      g = 0; acc = 1'b0;
      while (!acc && g < 500) begin
        @(negedge clk);
        acc = in_ready;
        tick();
        g++;
      end
      if (!acc) begin
        checks++;
        failures++;
        $display("FAIL send_timeout index=%0d got=no_accept expected=accept", i);
      end
      in_valid = 1'b0; in_last = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 3000) begin tick(); n++; end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic finish_stream(input int exp_unk);
    wait_done();
    chk("tokens_outstanding", 32'(exp_q.size()), 32'd0);
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("unk_cnt", 32'(unk_cnt), 32'(exp_unk));
    exp_q.delete();
    cs = 1'b0;
    tick(); tick();
  endtask

  task automatic run_stream(input logic [7:0] s[$], input bit use_model, input int exp_unk,
                            input bit gaps);
    int unk;
    unk = exp_unk;
    if (use_model) model_push(s, unk);
    cs = 1'b1;
    send_stream(s, gaps);
    finish_stream(unk);
  endtask

  initial begin
    logic [7:0] s[$];
    int n;
    rst_n = 1'b0; cs = 1'b0; vocab_we = 1'b0; vocab_waddr = '0; vocab_wlen = '0;
    vocab_wdata = '0; in_valid = 1'b0; in_sym = '0; in_last = 1'b0;
    for (int v = 0; v < 16; v++) begin
      m_len[v] = 0;
      for (int k = 0; k < 4; k++) m_sym[v][k] = 8'h00;
    end
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_unk_cnt", 32'(unk_cnt), 32'd0);
    chk("idle_out_token", 32'(out_token), 32'd0);

    write_vocab(0, 1, SA, 8'h00, 8'h00, 8'h00);
    write_vocab(1, 2, SA, SB, 8'h00, 8'h00);
    write_vocab(2, 3, SA, SB, SC, 8'h00);
    write_vocab(3, 1, SB, 8'h00, 8'h00, 8'h00);

    // "abcab" -> 2 (len 3), 1 (len 2, last)
    push_exp(2, 3, 1'b0, 1'b0, 8'h00);
    push_exp(1, 2, 1'b0, 1'b1, 8'h00);
    s = '{SA, SB, SC, SA, SB};
    run_stream(s, 1'b0, 0, 1'b0);

    // "x" -> unmatched
    push_exp(15, 1, 1'b1, 1'b1, FALLBACK ? SX : 8'h00);
    s = '{SX};
    run_stream(s, 1'b0, 1, 1'b0);

    // duplicate of entry 1 at index 4: lowest index wins; unk_cnt cleared
    write_vocab(4, 2, SA, SB, 8'h00, 8'h00);
    push_exp(1, 2, 1'b0, 1'b1, 8'h00);
    s = '{SA, SB};
    run_stream(s, 1'b0, 0, 1'b0);

    // sink stalls for 5 cycles while the token is presented
    rdy_mode = 2;
    tick(); tick();
    push_exp(2, 3, 1'b0, 1'b1, 8'h00);
    cs = 1'b1;
    s = '{SA, SB, SC};
    send_stream(s, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_token", 32'(out_token), 32'd2);
      chk("hold_len", 32'(out_len), 32'd3);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    rdy_mode = 0;
    finish_stream(0);

    // abort mid-scan
    cs = 1'b1;
    s = '{SA, SB};
    send_stream(s, 1'b0);
    tick(); tick();
    chk("scan_busy", 32'(busy), 32'd1);
    cs = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();

    // restart "b" with a vocab write attempted during the scan
    push_exp(3, 1, 1'b0, 1'b1, 8'h00);
    cs = 1'b1;
    s = '{SB};
    send_stream(s, 1'b0);
    tick();
    vocab_we = 1'b1; vocab_waddr = 4'd3; vocab_wlen = 3'd1; vocab_wdata = 32'(SC);
    tick();
    vocab_we = 1'b0;
    chk("scan_busy_we", 32'(busy), 32'd1);
    finish_stream(0);
    s = '{SC};
    run_stream(s, 1'b1, 0, 1'b0);
    s = '{SB};
    run_stream(s, 1'b1, 0, 1'b0);

    // random vocabulary and streams with random sink stalls and source gaps
    for (int v = 0; v < 16; v++) begin
      write_vocab(v, int'($urandom_range(0, 4)),
                  8'(SA + 8'($urandom_range(0, 3))), 8'(SA + 8'($urandom_range(0, 3))),
                  8'(SA + 8'($urandom_range(0, 3))), 8'(SA + 8'($urandom_range(0, 3))));
    end
    rdy_mode = 1;
    for (int t = 0; t < 20; t++) begin
      s.delete();
      n = int'($urandom_range(1, 10));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) == 0) s.push_back(8'h7A);
        else s.push_back(8'(SA + 8'($urandom_range(0, 3))));
      end
      run_stream(s, 1'b1, 0, 1'b1);
    end
    rdy_mode = 0;

    // reset in the middle of filling
    cs = 1'b1;
    tick();
    in_valid = 1'b1; in_sym = SA; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("fill_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("rst_fill_busy", 32'(busy), 32'd0);
    chk("rst_fill_in_ready", 32'(in_ready), 32'd0);
    chk("rst_fill_valid", 32'(out_valid), 32'd0);
    chk("rst_fill_outs", 32'({out_token, out_len, out_unk, out_last, out_sym}), 32'd0);
    chk("rst_fill_unk_cnt", 32'(unk_cnt), 32'd0);
    cs = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int v = 0; v < 16; v++) m_len[v] = 0;
    s = '{SA};
    run_stream(s, 1'b1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
